// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - front-end hazard sequencing for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 0,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_mem_read,
    input  logic             branch_taken_EX,
    input  logic             imem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH      = 2'd1,
        FETCH_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES);

    state_t     state, state_nxt;
    logic [2:0] fc, fc_nxt;
    logic       stall_inc;
    logic [1:0] flush_inc;
    logic       load_use;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign load_use = EX_mem_read && (EX_rd != 5'd0) &&
                      ((ID_use_rs1 && (EX_rd == ID_rs1)) ||
                       (ID_use_rs2 && (EX_rd == ID_rs2)));

    assign state_out = state;

    always_comb begin
        state_nxt    = RUN;
        fc_nxt       = fc;
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 2'd0;
        if (!reset) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else if (branch_taken_EX) begin
            // Redirect cycle squashes both the IF/ID slot and the ID/EX slot.
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            flush_inc    = 2'd2;
            if (FLUSH_CYCLES > 0) begin
                state_nxt = FLUSH;
                fc_nxt    = FC_INIT;
            end
        end else if (state == FLUSH) begin
            IF_ID_flush = 1'b1;
            flush_inc   = 2'd1;
            fc_nxt      = fc - 3'd1;
            state_nxt   = (fc <= 3'd1) ? RUN : FLUSH;
        end else if (!imem_ready) begin
            // Let ID drain and refill IF/ID with a NOP while the PC holds.
            PC_write    = 1'b0;
            IF_ID_flush = 1'b1;
            stall_inc   = 1'b1;
            state_nxt   = (state == RUN || state == FETCH_WAIT) ? FETCH_WAIT : RUN;
        end else if (load_use) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            stall_inc    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            fc        <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            fc        <= fc_nxt;
            stall_cnt <= sat_add(stall_cnt, {1'b0, stall_inc});
            flush_cnt <= sat_add(flush_cnt, flush_inc);
        end
    end

endmodule
